// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: merges stage stall requests into a per-register hold vector,
// qualifies EX redirects into flushes, drops wrong-path fetches, counts stalls and watches for memory hangs.
module pipe_stall_ctrl #(
    parameter int PIPE_N  = 6,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_stall_req,
    input  logic              id_stall_req,
    input  logic              mem_stall_req,
    input  logic              jump_i,
    output logic [PIPE_N-1:0] stall_o,
    output logic              flush_o,
    output logic              if_discard_o,
    output logic              mem_timeout_o,
    output logic [CNT_W-1:0]  stall_cycles_o
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        IF_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              wd_first;
    logic [WD_W-1:0]   wd_cnt_reg, wd_cnt_next;
    logic              timeout_reg, timeout_next;
    logic              discard_pending_reg, discard_pending_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;

    // Deepest requester wins; each mask holds every register upstream of it as well.
    generate
        for (genvar gi = 0; gi < PIPE_N; gi++) begin : g_stall
            if (gi <= 1) begin : g_front
                assign stall_o[gi] = ~rst & (mem_stall_req | id_stall_req | if_stall_req);
            end else if (gi == 2) begin : g_idex
                assign stall_o[gi] = ~rst & (mem_stall_req | id_stall_req);
            end else if (gi <= 4) begin : g_back
                assign stall_o[gi] = ~rst & mem_stall_req;
            end else begin : g_rsvd
                assign stall_o[gi] = 1'b0;
            end
        end
    endgenerate

    // A redirect while EX is held is dropped; EX re-presents it once released.
    assign flush_o        = ~rst & jump_i & ~stall_o[3];
    assign if_discard_o   = discard_pending_reg & ~if_stall_req;
    assign mem_timeout_o  = timeout_reg;
    assign stall_cycles_o = stall_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = RUN;
        if (mem_stall_req) begin
            state_next = MEM_WAIT;
        end else if (if_stall_req) begin
            state_next = IF_WAIT;
        end
    end

    always_comb begin
        wd_first = (state_reg != MEM_WAIT);
    end

    // The first cycle of a memory wait counts as one; the count saturates at the limit.
    always_comb begin
        wd_cnt_next = '0;
        if (mem_stall_req) begin
            if (wd_first) begin
                wd_cnt_next = WD_W'(1);
            end else if (wd_cnt_reg == WD_LIMIT) begin
                wd_cnt_next = wd_cnt_reg;
            end else begin
                wd_cnt_next = wd_cnt_reg + WD_W'(1);
            end
        end
        timeout_next = timeout_reg | (wd_cnt_next == WD_LIMIT);
    end

    always_comb begin
        discard_pending_next = discard_pending_reg;
        if (if_discard_o) begin
            discard_pending_next = 1'b0;
        end else if (flush_o && if_stall_req) begin
            discard_pending_next = 1'b1;
        end
        stall_cnt_next = stall_o[0] ? stall_cnt_reg + CNT_W'(1) : stall_cnt_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_reg          <= '0;
            timeout_reg         <= 1'b0;
            discard_pending_reg <= 1'b0;
            stall_cnt_reg       <= '0;
        end else begin
            wd_cnt_reg          <= wd_cnt_next;
            timeout_reg         <= timeout_next;
            discard_pending_reg <= discard_pending_next;
            stall_cnt_reg       <= stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: stimulus queues hand-computed per-cycle expectations,
// a monitor compares them against the DUT mid-cycle.
module tb_pipe_stall_ctrl;

    localparam int PIPE_N  = 6;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_stall_req, id_stall_req, mem_stall_req, jump_i;
    logic [PIPE_N-1:0] stall_o;
    logic              flush_o, if_discard_o, mem_timeout_o;
    logic [CNT_W-1:0]  stall_cycles_o;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        disc;
        logic        to;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = 0;

    pipe_stall_ctrl #(.PIPE_N(PIPE_N), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_stall_req   (if_stall_req),
        .id_stall_req   (id_stall_req),
        .mem_stall_req  (mem_stall_req),
        .jump_i         (jump_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .if_discard_o   (if_discard_o),
        .mem_timeout_o  (mem_timeout_o),
        .stall_cycles_o (stall_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, field, got, want);
        end
    endtask

    // Monitor: one expectation per driven cycle, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.name, "stall_o", 32'(stall_o), 32'(e.stall));
                chk(e.name, "flush_o", 32'(flush_o), 32'(e.flush));
                chk(e.name, "if_discard_o", 32'(if_discard_o), 32'(e.disc));
                chk(e.name, "mem_timeout_o", 32'(mem_timeout_o), 32'(e.to));
                chk(e.name, "stall_cycles_o", stall_cycles_o, e.cnt);
                $display("txn %-14s stall=%02h flush=%0b disc=%0b to=%0b cnt=%0d",
                         e.name, stall_o, flush_o, if_discard_o, mem_timeout_o, stall_cycles_o);
            end
        end
    end

    task automatic step(input logic r, input logic i_if, input logic i_id, input logic i_mem,
                        input logic i_j, input logic [5:0] es, input logic ef, input logic ed,
                        input logic et, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; if_stall_req = i_if; id_stall_req = i_id; mem_stall_req = i_mem; jump_i = i_j;
        if (r) exp_cnt = 0;
        e.stall = es; e.flush = ef; e.disc = ed; e.to = et; e.cnt = exp_cnt; e.name = nm;
        exp_q.push_back(e);
        if (es[0] && !r) exp_cnt = exp_cnt + 1;
    endtask

    initial begin
        rst = 1'b1; if_stall_req = 1'b0; id_stall_req = 1'b0; mem_stall_req = 1'b0; jump_i = 1'b0;
        //    rst if  id  mem jmp  stall  fl  dis to
        step(1, 0, 0, 0, 0, 6'h00, 0, 0, 0, "reset");
        step(1, 0, 0, 0, 0, 6'h00, 0, 0, 0, "reset");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, "idle");
        // Reset asserted in the middle of a memory stall
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 6'h1F, 0, 0, 0, "mem_pre_rst");
        step(1, 0, 0, 1, 0, 6'h00, 0, 0, 0, "rst_mid_stall");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, "after_rst");
        // Load-use bubble
        step(0, 0, 1, 0, 0, 6'h07, 0, 0, 0, "load_use");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, "load_use_end");
        // Priority of deepest requester
        step(0, 0, 1, 1, 0, 6'h1F, 0, 0, 0, "prio_id_mem");
        step(0, 0, 1, 0, 0, 6'h07, 0, 0, 0, "prio_id");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, "prio_none");
        step(0, 1, 1, 0, 0, 6'h07, 0, 0, 0, "prio_if_id");
        step(0, 1, 0, 0, 0, 6'h03, 0, 0, 0, "prio_if");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, "idle");
        // Jump while EX is held, then re-presented
        step(0, 0, 0, 1, 1, 6'h1F, 0, 0, 0, "jump_mem_held");
        step(0, 0, 0, 0, 1, 6'h00, 1, 0, 0, "jump_released");
        step(0, 0, 1, 0, 1, 6'h07, 1, 0, 0, "jump_id_stall");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, "idle");
        // Wrong-path fetch outstanding at redirect
        step(0, 1, 0, 0, 1, 6'h03, 1, 0, 0, "wp_flush");
        step(0, 1, 0, 0, 0, 6'h03, 0, 0, 0, "wp_wait1");
        step(0, 1, 0, 0, 0, 6'h03, 0, 0, 0, "wp_wait2");
        step(0, 0, 0, 0, 0, 6'h00, 0, 1, 0, "wp_return");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, "wp_after");
        // Redirect with no fetch outstanding never discards
        step(0, 0, 0, 0, 1, 6'h00, 1, 0, 0, "np_flush");
        step(0, 1, 0, 0, 0, 6'h03, 0, 0, 0, "np_wait1");
        step(0, 1, 0, 0, 0, 6'h03, 0, 0, 0, "np_wait2");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, "np_return");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, "np_after");
        // Second flush while pending does not stack
        step(0, 1, 0, 0, 1, 6'h03, 1, 0, 0, "st_flush1");
        step(0, 1, 0, 0, 1, 6'h03, 1, 0, 0, "st_flush2");
        step(0, 0, 0, 0, 0, 6'h00, 0, 1, 0, "st_return");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, "st_after");
        // Flush coinciding with the discard pulse clears pending
        step(0, 1, 0, 0, 1, 6'h03, 1, 0, 0, "co_flush");
        step(0, 0, 0, 0, 1, 6'h00, 1, 1, 0, "co_pulse_flush");
        step(0, 1, 0, 0, 0, 6'h03, 0, 0, 0, "co_refetch");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, "co_no_disc");
        // Watchdog: one short of the limit does not trip
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 6'h1F, 0, 0, 0, "wd_7");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, "wd_7_drop");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, "wd_7_idle");
        // Watchdog: exactly at the limit trips and stays sticky
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 6'h1F, 0, 0, 0, "wd_8");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 1, "wd_8_drop");
        step(0, 1, 0, 0, 0, 6'h03, 0, 0, 1, "wd_sticky");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 1, "wd_sticky2");
        step(1, 0, 0, 0, 0, 6'h00, 0, 0, 0, "wd_rst");
        step(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, "wd_after_rst");

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
